// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage and its forwarding mux.
// Default widths, the hard-wired zero register index and the control-bundle
// field layout that the EX stage decodes.
package id_ex_operand_stage_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_REG_W  = 5;
  localparam int unsigned DEFAULT_CTRL_W = 16;

  // Register index that always reads as zero
  localparam int unsigned REG_ZERO = 0;

  // Control bundle layout: [EX fields | MEM fields | WB fields], LSB first
  localparam int unsigned CTRL_EX_LSB  = 0;
  localparam int unsigned CTRL_MEM_LSB = 8;
  localparam int unsigned CTRL_WB_LSB  = 12;

  // Non-empty, ascending field groups that fit inside the bundle
  function automatic bit ctrl_layout_ok(input int unsigned ctrl_w);
    return (CTRL_EX_LSB < CTRL_MEM_LSB) &&
           (CTRL_MEM_LSB < CTRL_WB_LSB) &&
           (CTRL_WB_LSB < ctrl_w);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_operand_forward_mux.sv
// Operand forwarding select: zero register, then EX/MEM, then MEM/WB,
// then register-file data. Purely combinational.
module operand_forward_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned REG_W  = DEFAULT_REG_W
) (
  input  logic [REG_W-1:0]  idx,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_write_reg,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_write_reg,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] operand_c
);

  // Priority select; the younger EX/MEM result wins over MEM/WB
  always_comb begin
    operand_c = rf_data;
    if (idx == REG_W'(REG_ZERO)) begin
      operand_c = '0;
    end else if (exmem_reg_write && (exmem_write_reg == idx)) begin
      operand_c = exmem_result;
    end else if (memwb_reg_write && (memwb_write_reg == idx)) begin
      operand_c = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: captures forwarded register operands for the
// decoded instruction, inserts a bubble on load-use hazards and squashes
// on flush. Optional stall/flush event counters under ID_EX_STALL_CNT_EN.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned REG_W  = DEFAULT_REG_W,
  parameter int unsigned CTRL_W = DEFAULT_CTRL_W
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inPc,
  input  logic [REG_W-1:0]  inRs,
  input  logic [REG_W-1:0]  inRt,
  input  logic [REG_W-1:0]  inRd,
  input  logic              inUsesRt,
  input  logic [DATA_W-1:0] inRsData,
  input  logic [DATA_W-1:0] inRtData,
  input  logic [DATA_W-1:0] inImm,
  input  logic [REG_W-1:0]  inWriteReg,
  input  logic              inMemRead,
  input  logic [CTRL_W-1:0] inCtrl,
  input  logic              exmemRegWrite,
  input  logic [REG_W-1:0]  exmemWriteReg,
  input  logic [DATA_W-1:0] exmemResult,
  input  logic              memwbRegWrite,
  input  logic [REG_W-1:0]  memwbWriteReg,
  input  logic [DATA_W-1:0] memwbData,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outPc,
  output logic [DATA_W-1:0] outRsData,
  output logic [DATA_W-1:0] outRtData,
  output logic [DATA_W-1:0] outImm,
  output logic [REG_W-1:0]  outRs,
  output logic [REG_W-1:0]  outRt,
  output logic [REG_W-1:0]  outWriteReg,
  output logic              outMemRead,
  output logic [CTRL_W-1:0] outCtrl
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]       stallCount,
  output logic [31:0]       flushCount
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Reject control layouts the EX stage cannot decode
  if (!ctrl_layout_ok(CTRL_W)) begin : g_ctrl_layout_bad
    $error("id_ex_operand_stage: CTRL_W too narrow for control field layout");
  end

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic              capture_c;
  logic              free_c;
  logic              hazard_c;
  logic [DATA_W-1:0] rs_fwd_c;
  logic [DATA_W-1:0] rt_fwd_c;

  // The destination is already resolved upstream into inWriteReg
  logic unused_rd;
  assign unused_rd = ^inRd;

  assign outValid = (state_q == ST_FULL);

  // Slot availability and load-use detection against the held bundle
  always_comb begin
    free_c   = !outValid || outReady;
    hazard_c = outValid && outMemRead &&
               (outWriteReg != REG_W'(REG_ZERO)) &&
               ((outWriteReg == inRs) || (inUsesRt && (outWriteReg == inRt)));
    inReady  = free_c && !hazard_c && !flush;
  end

  operand_forward_mux #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_rs_fwd (
    .idx             (inRs),
    .rf_data         (inRsData),
    .exmem_reg_write (exmemRegWrite),
    .exmem_write_reg (exmemWriteReg),
    .exmem_result    (exmemResult),
    .memwb_reg_write (memwbRegWrite),
    .memwb_write_reg (memwbWriteReg),
    .memwb_data      (memwbData),
    .operand_c       (rs_fwd_c)
  );

  // rt is forwarded unconditionally; EX ignores it when unused
  operand_forward_mux #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_rt_fwd (
    .idx             (inRt),
    .rf_data         (inRtData),
    .exmem_reg_write (exmemRegWrite),
    .exmem_write_reg (exmemWriteReg),
    .exmem_result    (exmemResult),
    .memwb_reg_write (memwbRegWrite),
    .memwb_write_reg (memwbWriteReg),
    .memwb_data      (memwbData),
    .operand_c       (rt_fwd_c)
  );

  // Control state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and capture enable: flush > bubble > accept > drain > hold
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (free_c) begin
      if (hazard_c) begin
        state_d = ST_EMPTY;
      end else if (inValid) begin
        state_d   = ST_FULL;
        capture_c = 1'b1;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // Operand bundle registers; only written on accept, so they hold on stall
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      outPc       <= '0;
      outRsData   <= '0;
      outRtData   <= '0;
      outImm      <= '0;
      outRs       <= '0;
      outRt       <= '0;
      outWriteReg <= '0;
      outMemRead  <= 1'b0;
      outCtrl     <= '0;
    end else if (capture_c) begin
      outPc       <= inPc;
      outRsData   <= rs_fwd_c;
      outRtData   <= rt_fwd_c;
      outImm      <= inImm;
      outRs       <= inRs;
      outRt       <= inRt;
      outWriteReg <= inWriteReg;
      outMemRead  <= inMemRead;
      outCtrl     <= inCtrl;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Event counters: load-use stalls of a pending instruction and squashed bundles
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (hazard_c && free_c && inValid) begin
        stallCount <= stallCount + 32'd1;
      end
      if (flush && outValid) begin
        flushCount <= flushCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        resetN;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inPc;
  logic [4:0]  inRs, inRt, inRd;
  logic        inUsesRt;
  logic [31:0] inRsData, inRtData, inImm;
  logic [4:0]  inWriteReg;
  logic        inMemRead;
  logic [15:0] inCtrl;
  logic        exmemRegWrite;
  logic [4:0]  exmemWriteReg;
  logic [31:0] exmemResult;
  logic        memwbRegWrite;
  logic [4:0]  memwbWriteReg;
  logic [31:0] memwbData;
  logic        outValid;
  logic        outReady;
  logic [31:0] outPc, outRsData, outRtData, outImm;
  logic [4:0]  outRs, outRt, outWriteReg;
  logic        outMemRead;
  logic [15:0] outCtrl;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stallCount, flushCount;
`endif

  id_ex_operand_stage dut (
    .clk           (clk),
    .resetN        (resetN),
    .flush         (flush),
    .inValid       (inValid),
    .inReady       (inReady),
    .inPc          (inPc),
    .inRs          (inRs),
    .inRt          (inRt),
    .inRd          (inRd),
    .inUsesRt      (inUsesRt),
    .inRsData      (inRsData),
    .inRtData      (inRtData),
    .inImm         (inImm),
    .inWriteReg    (inWriteReg),
    .inMemRead     (inMemRead),
    .inCtrl        (inCtrl),
    .exmemRegWrite (exmemRegWrite),
    .exmemWriteReg (exmemWriteReg),
    .exmemResult   (exmemResult),
    .memwbRegWrite (memwbRegWrite),
    .memwbWriteReg (memwbWriteReg),
    .memwbData     (memwbData),
    .outValid      (outValid),
    .outReady      (outReady),
    .outPc         (outPc),
    .outRsData     (outRsData),
    .outRtData     (outRtData),
    .outImm        (outImm),
    .outRs         (outRs),
    .outRt         (outRt),
    .outWriteReg   (outWriteReg),
    .outMemRead    (outMemRead),
    .outCtrl       (outCtrl)
`ifdef ID_EX_STALL_CNT_EN
    ,
    .stallCount    (stallCount),
    .flushCount    (flushCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model of what EX sees
  typedef struct {
    bit        valid;
    bit [31:0] pc, rs_d, rt_d, imm;
    bit [4:0]  rs, rt, wr;
    bit        mr;
    bit [15:0] ctrl;
  } bundle_t;

  bundle_t     m;
  bit [31:0]   m_stalls, m_flushes;

  function automatic bit [31:0] operand_value(input bit [4:0] idx, input bit [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (exmemRegWrite && exmemWriteReg == idx) return exmemResult;
    if (memwbRegWrite && memwbWriteReg == idx) return memwbData;
    return rf;
  endfunction

  function automatic void model_reset();
    m = '{default: '0};
    m_stalls  = '0;
    m_flushes = '0;
  endfunction

  task automatic clear_inputs();
    flush = 0; inValid = 0; inPc = 0; inRs = 0; inRt = 0; inRd = 0;
    inUsesRt = 0; inRsData = 0; inRtData = 0; inImm = 0; inWriteReg = 0;
    inMemRead = 0; inCtrl = 0; exmemRegWrite = 0; exmemWriteReg = 0;
    exmemResult = 0; memwbRegWrite = 0; memwbWriteReg = 0; memwbData = 0;
    outReady = 0;
  endtask

  task automatic rand_inputs();
    flush         = ($urandom_range(0, 9) == 0);
    inValid       = ($urandom_range(0, 4) != 0);
    inPc          = $urandom;
    inRs          = 5'($urandom_range(0, 7));
    inRt          = 5'($urandom_range(0, 7));
    inRd          = 5'($urandom);
    inUsesRt      = 1'($urandom);
    inRsData      = $urandom;
    inRtData      = $urandom;
    inImm         = $urandom;
    inWriteReg    = 5'($urandom_range(0, 7));
    inMemRead     = ($urandom_range(0, 2) == 0);
    inCtrl        = 16'($urandom);
    exmemRegWrite = 1'($urandom);
    exmemWriteReg = 5'($urandom_range(0, 7));
    exmemResult   = $urandom;
    memwbRegWrite = 1'($urandom);
    memwbWriteReg = 5'($urandom_range(0, 7));
    memwbData     = $urandom;
    outReady      = ($urandom_range(0, 3) != 0);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".outValid"}, 64'(outValid), 64'(m.valid));
    if (m.valid) begin
      chk({tag, ".outPc"},       64'(outPc),       64'(m.pc));
      chk({tag, ".outRsData"},   64'(outRsData),   64'(m.rs_d));
      chk({tag, ".outRtData"},   64'(outRtData),   64'(m.rt_d));
      chk({tag, ".outImm"},      64'(outImm),      64'(m.imm));
      chk({tag, ".outRs"},       64'(outRs),       64'(m.rs));
      chk({tag, ".outRt"},       64'(outRt),       64'(m.rt));
      chk({tag, ".outWriteReg"}, 64'(outWriteReg), 64'(m.wr));
      chk({tag, ".outMemRead"},  64'(outMemRead),  64'(m.mr));
      chk({tag, ".outCtrl"},     64'(outCtrl),     64'(m.ctrl));
    end
`ifdef ID_EX_STALL_CNT_EN
    chk({tag, ".stallCount"}, 64'(stallCount), 64'(m_stalls));
    chk({tag, ".flushCount"}, 64'(flushCount), 64'(m_flushes));
`endif
  endtask

  // One cycle with the currently driven inputs (entered just after a posedge)
  task automatic step(input string tag);
    bit free, haz;
    bundle_t nxt;
    #1;
    free = !m.valid || outReady;
    haz  = m.valid && m.mr && (m.wr != 0) &&
           ((m.wr == inRs) || (inUsesRt && (m.wr == inRt)));
    chk({tag, ".inReady"}, 64'(inReady), 64'(free && !haz && !flush));
    nxt = m;
    if (flush) begin
      nxt.valid = 0;
    end else if (free && haz) begin
      nxt.valid = 0;
    end else if (free && inValid) begin
      nxt.valid = 1;
      nxt.pc    = inPc;
      nxt.rs_d  = operand_value(inRs, inRsData);
      nxt.rt_d  = operand_value(inRt, inRtData);
      nxt.imm   = inImm;
      nxt.rs    = inRs;
      nxt.rt    = inRt;
      nxt.wr    = inWriteReg;
      nxt.mr    = inMemRead;
      nxt.ctrl  = inCtrl;
    end else if (free) begin
      nxt.valid = 0;
    end
    if (haz && free && inValid) m_stalls++;
    if (flush && m.valid) m_flushes++;
    @(posedge clk);
    m = nxt;
    #1;
    check_outputs(tag);
  endtask

  logic [31:0] snap_pc, snap_rs;

  initial begin
    clear_inputs();
    model_reset();
    resetN = 0;
    #12;
    chk("reset.outValid",  64'(outValid),  64'd0);
    chk("reset.outPc",     64'(outPc),     64'd0);
    chk("reset.outRsData", 64'(outRsData), 64'd0);
    chk("reset.outCtrl",   64'(outCtrl),   64'd0);
    resetN = 1;
    @(posedge clk);
    #1;

    // Plain accept
    inValid = 1; inRs = 3; inRsData = 32'h11; outReady = 1;
    step("accept");
    chk("accept.rsData", 64'(outRsData), 64'h11);

    // Forwarding priority
    inRs = 5; exmemRegWrite = 1; exmemWriteReg = 5; exmemResult = 32'hAA;
    memwbRegWrite = 1; memwbWriteReg = 5; memwbData = 32'hBB;
    step("fwd_exmem");
    chk("fwd_exmem.rsData", 64'(outRsData), 64'hAA);
    exmemRegWrite = 0;
    step("fwd_memwb");
    chk("fwd_memwb.rsData", 64'(outRsData), 64'hBB);
    inRs = 0; inRsData = 32'h55; exmemRegWrite = 1; exmemWriteReg = 0; memwbWriteReg = 0;
    step("fwd_zero");
    chk("fwd_zero.rsData", 64'(outRsData), 64'h0);

    // Load-use hazard on rt
    clear_inputs();
    outReady = 1; inValid = 1; inMemRead = 1; inWriteReg = 8; inPc = 32'h100;
    step("load");
    inMemRead = 0; inWriteReg = 9; inRs = 1; inRt = 8; inUsesRt = 1; inPc = 32'h104;
    step("loaduse_bubble");
    chk("loaduse.outValid", 64'(outValid), 64'd0);
    step("loaduse_retry");
    chk("loaduse_retry.outPc", 64'(outPc), 64'h104);
    // Same indices but rt unused: no stall
    inMemRead = 1; inWriteReg = 8; inPc = 32'h200; inUsesRt = 0; inRt = 2;
    step("load2");
    inMemRead = 0; inWriteReg = 9; inRt = 8; inUsesRt = 0; inPc = 32'h204;
    step("no_stall");
    chk("no_stall.outPc", 64'(outPc), 64'h204);

    // Backpressure: outputs frozen while EX stalls
    outReady = 0;
    snap_pc = outPc; snap_rs = outRsData;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      flush = 0; outReady = 0;
      step("backpressure");
      chk("backpressure.pc_stable", 64'(outPc), 64'(snap_pc));
      chk("backpressure.rs_stable", 64'(outRsData), 64'(snap_rs));
    end

    // Flush while full
    clear_inputs();
    flush = 1; inValid = 1; outReady = 0;
    step("flush");
    chk("flush.outValid", 64'(outValid), 64'd0);
`ifdef ID_EX_STALL_CNT_EN
    chk("flush.flushCount", 64'(flushCount), 64'd1);
`endif

    // Asynchronous reset while full
    clear_inputs();
    inValid = 1; outReady = 1; inPc = 32'h300; inImm = 32'h77;
    step("prefill");
    #2;
    resetN = 0;
    #1;
    model_reset();
    chk("async_rst.outValid", 64'(outValid), 64'd0);
    chk("async_rst.outPc",    64'(outPc),    64'd0);
    chk("async_rst.outImm",   64'(outImm),   64'd0);
`ifdef ID_EX_STALL_CNT_EN
    chk("async_rst.flushCount", 64'(flushCount), 64'd0);
`endif
    #2;
    resetN = 1;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
